instr_decode_stage: RTL and testbench

Decode stage directly downstream of the program counter and instruction memory. Accepts the 16-bit instruction word and its PC, splits fields, reads an 8×16 register file, and sign-extends immediates. Results are registered into a valid/ready output stage that feeds execute. The register file and its write-back port live inside this block.

---
 rtl/instr_decode_stage_if.sv | 45 ++++
 rtl/instr_decode_stage.sv | 139 +++++++++++++
 tb/tb_instr_decode_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// Bus between fetch, the decode stage and execute: instruction offer, flush,
// register write-back and the registered decode results with their handshake.
interface instr_decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              wb_en;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [3:0]        out_opcode;
  logic [2:0]        out_funct;
  logic [2:0]        out_dst;
  logic [DATA_W-1:0] out_rs_data;
  logic [DATA_W-1:0] out_rt_data;
  logic [DATA_W-1:0] out_imm;
  logic [PC_W-1:0]   out_jtarget;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;
  logic              out_jump;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct, out_dst,
           out_rs_data, out_rt_data, out_imm, out_jtarget, out_reg_write,
           out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct, out_dst,
           out_rs_data, out_rt_data, out_imm, out_jtarget, out_reg_write,
           out_mem_read, out_mem_write, out_branch, out_jump, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Decode stage: field split, 8x16 register file with write-back bypass,
// immediate sign extension and a valid/ready registered output toward execute.
module instr_decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8,
  parameter int NREG   = 8
) (
  input logic           clk,
  input logic           reset,
  instr_decode_stage_if.slave bus
);

  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        opcode;
  logic [2:0]        rs, rt, rd, funct;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [2:0]        dst;
  logic              reg_write, mem_read, mem_write, branch, jump, illegal;
  logic              accept;

  logic              out_valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [3:0]        opcode_q;
  logic [2:0]        funct_q, dst_q;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [PC_W-1:0]   jtarget_q;
  logic              reg_write_q, mem_read_q, mem_write_q, branch_q, jump_q, illegal_q;

  assign opcode = bus.in_instr[15:12];
  assign rs     = bus.in_instr[11:9];
  assign rt     = bus.in_instr[8:6];
  assign rd     = bus.in_instr[5:3];
  assign funct  = bus.in_instr[2:0];
  assign imm    = {{(DATA_W-6){bus.in_instr[5]}}, bus.in_instr[5:0]};

  // Same-cycle write-back wins over the stored value; r0 is never bypassed.
  assign rs_data = (bus.wb_en && bus.wb_addr == rs && rs != 3'd0) ? bus.wb_data : regs[rs];
  assign rt_data = (bus.wb_en && bus.wb_addr == rt && rt != 3'd0) ? bus.wb_data : regs[rt];

  always_comb begin
    dst       = 3'd0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      4'd0: begin
        dst = rd;
        if (funct <= 3'd4) reg_write = 1'b1;
        else               illegal   = 1'b1;
      end
      4'd1, 4'd2, 4'd3: begin
        dst       = rt;
        reg_write = 1'b1;
      end
      4'd4: begin
        dst       = rt;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      4'd5:    mem_write = 1'b1;
      4'd6:    branch    = 1'b1;
      4'd7:    jump      = 1'b1;
      default: illegal   = 1'b1;
    endcase
    if (dst == 3'd0) reg_write = 1'b0;
  end

  assign bus.in_ready = reset && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != 3'd0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      opcode_q    <= '0;
      funct_q     <= '0;
      dst_q       <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      jtarget_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= bus.in_pc;
      opcode_q    <= opcode;
      funct_q     <= funct;
      dst_q       <= dst;
      rs_data_q   <= rs_data;
      rt_data_q   <= rt_data;
      imm_q       <= imm;
      jtarget_q   <= bus.in_instr[PC_W-1:0];
      reg_write_q <= reg_write;
      mem_read_q  <= mem_read;
      mem_write_q <= mem_write;
      branch_q    <= branch;
      jump_q      <= jump;
      illegal_q   <= illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_opcode    = opcode_q;
  assign bus.out_funct     = funct_q;
  assign bus.out_dst       = dst_q;
  assign bus.out_rs_data   = rs_data_q;
  assign bus.out_rt_data   = rt_data_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_jtarget   = jtarget_q;
  assign bus.out_reg_write = reg_write_q;
  assign bus.out_mem_read  = mem_read_q;
  assign bus.out_mem_write = mem_write_q;
  assign bus.out_branch    = branch_q;
  assign bus.out_jump      = jump_q;
  assign bus.out_illegal   = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: a reference decoder with a shadow
// register file pushes expected results at accept; outputs are compared at negedge.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic [2:0]  dst;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [7:0]  jtarget;
    logic        rw, mr, mw, br, jp, ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t        q[$];
  logic        mdl_valid = 1'b0;
  logic [15:0] shadow [8];

  instr_decode_stage_if #(.DATA_W(16), .PC_W(8)) bus();

  instr_decode_stage #(.DATA_W(16), .PC_W(8), .NREG(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] ins, input logic [7:0] pc);
    exp_t e;
    logic [2:0] rs, rt;
    e = '0;
    rs = ins[11:9];
    rt = ins[8:6];
    e.pc      = pc;
    e.opcode  = ins[15:12];
    e.funct   = ins[2:0];
    e.imm     = {{10{ins[5]}}, ins[5:0]};
    e.jtarget = ins[7:0];
    e.rs_data = (rs == 3'd0) ? 16'h0 : (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : shadow[rs];
    e.rt_data = (rt == 3'd0) ? 16'h0 : (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : shadow[rt];
    case (ins[15:12])
      4'd0: begin e.dst = ins[5:3]; if (ins[2:0] < 3'd5) e.rw = 1'b1; else e.ill = 1'b1; end
      4'd1, 4'd2, 4'd3: begin e.dst = rt; e.rw = 1'b1; end
      4'd4: begin e.dst = rt; e.rw = 1'b1; e.mr = 1'b1; end
      4'd5: e.mw = 1'b1;
      4'd6: e.br = 1'b1;
      4'd7: e.jp = 1'b1;
      default: e.ill = 1'b1;
    endcase
    if (e.dst == 3'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic exp_t get_out();
    exp_t a;
    a = '{pc: bus.out_pc, opcode: bus.out_opcode, funct: bus.out_funct, dst: bus.out_dst,
          rs_data: bus.out_rs_data, rt_data: bus.out_rt_data, imm: bus.out_imm,
          jtarget: bus.out_jtarget, rw: bus.out_reg_write, mr: bus.out_mem_read,
          mw: bus.out_mem_write, br: bus.out_branch, jp: bus.out_jump, ill: bus.out_illegal};
    return a;
  endfunction

  function automatic logic mdl_ready();
    return !bus.flush && (!mdl_valid || bus.out_ready);
  endfunction

  // Advance one clock from negedge to negedge, updating the model first.
  task automatic tick();
    logic acc;
    acc = bus.in_valid && mdl_ready();
    if (mdl_valid && (bus.flush || bus.out_ready) && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(model(bus.in_instr, bus.in_pc));
    if (bus.flush)          mdl_valid = 1'b0;
    else if (acc)           mdl_valid = 1'b1;
    else if (bus.out_ready) mdl_valid = 1'b0;
    if (bus.wb_en && bus.wb_addr != 3'd0) shadow[bus.wb_addr] = bus.wb_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] ins, input logic [7:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t act;
    #1;
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got valid=%b ready=%b expected 0 0", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (act !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_out: got %h expected 0", act);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_addi();
    exp_t act;
    bus.out_ready = 1'b1;
    offer(16'h1045, 8'h03);
    tick();
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0]) begin
      errors++;
      $display("FAIL addi_model: got v=%b %h expected %h", bus.out_valid, act, (q.size() > 0) ? q[0] : exp_t'(0));
    end
    checks++;
    if (act.opcode !== 4'd1 || act.dst !== 3'd1 || act.imm !== 16'h0005 || act.rw !== 1'b1 || act.pc !== 8'h03) begin
      errors++;
      $display("FAIL addi_fields: got op=%h dst=%h imm=%h rw=%b pc=%h expected 1 1 0005 1 03",
               act.opcode, act.dst, act.imm, act.rw, act.pc);
    end
    offer(16'h107F, 8'h04);
    tick();
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] || act.imm !== 16'hFFFF) begin
      errors++;
      $display("FAIL addi_negimm: got v=%b imm=%h expected 1 FFFF", bus.out_valid, act.imm);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    exp_t act;
    wb_write(3'd1, 16'h0020);
    wb_write(3'd2, 16'h0037);
    offer(16'h0298, 8'h08);
    bus.wb_en = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h1234;
    tick();
    bus.wb_en = 1'b0;
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] || act.rs_data !== 16'h0020 ||
        act.rt_data !== 16'h1234 || act.dst !== 3'd3 || act.funct !== 3'd0) begin
      errors++;
      $display("FAIL bypass: got rs=%h rt=%h dst=%h funct=%h expected 0020 1234 3 0",
               act.rs_data, act.rt_data, act.dst, act.funct);
    end
    offer(16'h0298, 8'h09);
    tick();
    act = get_out();
    checks++;
    if (q.size() == 0 || act !== q[0] || act.rt_data !== 16'h1234) begin
      errors++;
      $display("FAIL bypass_stored: got rt=%h expected 1234", act.rt_data);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    exp_t act, held;
    bus.out_ready = 1'b0;
    offer(16'h0298, 8'h10);
    tick();
    held = get_out();
    offer(16'h1045, 8'h11);
    for (int i = 0; i < 5; i++) begin
      bus.wb_en = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 16'h0100 + 16'(i);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
      tick();
      act = get_out();
      checks++;
      if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] || act !== held) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, act, held);
      end
    end
    bus.wb_en = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] || act.pc !== 8'h11) begin
      errors++;
      $display("FAIL bp_next: got pc=%h expected 11", act.pc);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    exp_t act;
    bus.out_ready = 1'b0;
    offer(16'h1045, 8'h20);
    tick();
    offer(16'h0298, 8'h21);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got ready=%b valid=%b expected 0 1", bus.in_ready, bus.out_valid);
    end
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b expected 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] || act.pc !== 8'h21) begin
      errors++;
      $display("FAIL flush_retry: got v=%b pc=%h expected 1 21", bus.out_valid, act.pc);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal_jump();
    exp_t act;
    logic [15:0] ins [4];
    ins = '{16'h7012, 16'h9000, 16'h0295, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      offer(ins[i], 8'(8'h30 + i));
      bus.wb_en = (i == 3); bus.wb_addr = 3'd0; bus.wb_data = 16'hBEEF;
      tick();
      act = get_out();
      checks++;
      if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0]) begin
        errors++;
        $display("FAIL ill_model[%0d]: got %h expected %h", i, act, (q.size() > 0) ? q[0] : exp_t'(0));
      end
    end
    bus.wb_en = 1'b0;
    tick();
    act = get_out();
    checks++;
    if (act.rs_data !== 16'h0 || act.rt_data !== 16'h0) begin
      errors++;
      $display("FAIL r0_write: got rs=%h rt=%h expected 0000 0000", act.rs_data, act.rt_data);
    end
    bus.in_valid = 1'b0;
    tick();
    offer(16'h7012, 8'h40);
    tick();
    act = get_out();
    checks++;
    if (act.jp !== 1'b1 || act.jtarget !== 8'h12 || act.rw !== 1'b0) begin
      errors++;
      $display("FAIL jump: got jp=%b jt=%h rw=%b expected 1 12 0", act.jp, act.jtarget, act.rw);
    end
    offer(16'h9000, 8'h41);
    tick();
    act = get_out();
    checks++;
    if (act.ill !== 1'b1 || {act.rw, act.mr, act.mw, act.br, act.jp} !== 5'b0) begin
      errors++;
      $display("FAIL illegal: got ill=%b flags=%b expected 1 00000", act.ill, {act.rw, act.mr, act.mw, act.br, act.jp});
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t act;
    for (int i = 0; i < 60; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = 16'($urandom);
      bus.in_pc     = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.wb_en     = ($urandom_range(0, 1) != 0);
      bus.wb_addr   = 3'($urandom);
      bus.wb_data   = 16'($urandom);
      #1;
      checks++;
      if (bus.in_ready !== mdl_ready()) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus.in_ready, mdl_ready());
      end
      tick();
      act = get_out();
      checks++;
      if (bus.out_valid !== mdl_valid || (mdl_valid && (q.size() == 0 || act !== q[0]))) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got v=%b %h expected v=%b %h", i, bus.out_valid, act, mdl_valid,
                 (q.size() > 0) ? q[0] : exp_t'(0));
      end
    end
    bus.flush = 1'b0; bus.wb_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midstream();
    exp_t act;
    for (int r = 1; r < 8; r++) wb_write(3'(r), 16'hA000 + 16'(r));
    bus.out_ready = 1'b0;
    offer(16'h0298, 8'h50);
    tick();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    act = get_out();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || act !== exp_t'(0)) begin
      errors++;
      $display("FAIL mid_reset: got v=%b ready=%b %h expected 0 0 0", bus.out_valid, bus.in_ready, act);
    end
    q.delete();
    mdl_valid = 1'b0;
    for (int r = 0; r < 8; r++) shadow[r] = 16'h0;
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 1; r < 8; r++) begin
      offer({4'h0, 3'(r), 3'(r), 3'd1, 3'd0}, 8'(8'h60 + r));
      tick();
      act = get_out();
      checks++;
      if (bus.out_valid !== 1'b1 || q.size() == 0 || act !== q[0] ||
          act.rs_data !== 16'h0 || act.rt_data !== 16'h0) begin
        errors++;
        $display("FAIL reg_cleared[r%0d]: got rs=%h rt=%h expected 0000 0000", r, act.rs_data, act.rt_data);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    for (int r = 0; r < 8; r++) shadow[r] = 16'h0;
    test_reset();
    test_addi();
    test_bypass();
    test_backpressure();
    test_flush();
    test_illegal_jump();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
